// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shift_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  // Mode[1]=1 selects rotate regardless of Mode[0], so 2'b11 aliases ROL.
  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,
    MODE_SLA = 2'b01,
    MODE_ROL = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step for the iterative shifter, plus the per-step SLA
// sign-change indication that feeds the sticky overflow flag.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] next_d,
  output logic              ovfl_step
);

  always_comb begin
    next_d    = {1'b0, d[DATA_W-1:1]};
    ovfl_step = 1'b0;
    if (mode[1]) begin
      next_d = {d[DATA_W-2:0], d[DATA_W-1]};
    end else if (mode == MODE_SLA) begin
      next_d    = {d[DATA_W-2:0], 1'b0};
      ovfl_step = d[DATA_W-1] ^ d[DATA_W-2];
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one bit per clock, result and overflow held in
// output registers that only change when an operation completes.
module iter_shifter
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] Shift_In,
  input  logic [CNT_W-1:0]  Shift_Val,
  input  logic [1:0]        Mode,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] Shift_Out,
  output logic              Ovfl,
  output logic [1:0]        fsm_state
);

  // Handshake: a request is taken on the rising edge where start && ready;
  // start is ignored in every other cycle. done is a one-cycle pulse and
  // Shift_Out/Ovfl are valid from that cycle until the next completion.

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    count_q;
  logic [1:0]          mode_q;
  logic                ovfl_acc_q;
  logic [DATA_W-1:0]   result_q;
  logic                ovfl_q;
  logic [DATA_W-1:0]   step_d;
  logic                step_ovfl;

  shift_step u_step (
    .d         (data_q),
    .mode      (mode_q),
    .next_d    (step_d),
    .ovfl_step (step_ovfl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (Shift_Val != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (count_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The accumulating overflow is cleared on acceptance; the visible Ovfl
  // only changes together with Shift_Out when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      count_q    <= '0;
      mode_q     <= '0;
      ovfl_acc_q <= 1'b0;
      result_q   <= '0;
      ovfl_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            data_q     <= Shift_In;
            count_q    <= Shift_Val;
            mode_q     <= Mode;
            ovfl_acc_q <= 1'b0;
            if (Shift_Val == '0) begin
              result_q <= Shift_In;
              ovfl_q   <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          data_q     <= step_d;
          count_q    <= count_q - CNT_W'(1);
          ovfl_acc_q <= ovfl_acc_q | step_ovfl;
          if (count_q == CNT_W'(1)) begin
            result_q <= step_d;
            ovfl_q   <= ovfl_acc_q | step_ovfl;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign Shift_Out = result_q;
  assign Ovfl      = ovfl_q;
  assign fsm_state = state_q;

endmodule
